// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Reusable pipeline boundary register (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Carries an opaque WIDTH-bit payload plus a valid bit.
//     MODE 0 : classic enable/flush latch, in_ready = enable.
//     MODE 1 : elastic ready/valid stage with a 2-entry skid buffer; in_ready
//              comes from a flop, so out_ready never reaches in_ready
//              combinationally.
//   Also reports occupancy and a saturating count of valid entries discarded
//   by flush.
//
// Ports
//   CLK, nRST           clock (rising edge), async active-low reset
//   flush               drop every held entry this edge (beats enable)
//   enable              advance / stall gate, 0 freezes the stage
//   in_valid, in_data   upstream entry
//   in_ready            stage can take in_data this cycle
//   out_valid, out_data downstream entry
//   out_ready           downstream accepts (MODE 1 only)
//   occupancy           valid entries held (0..2)
//   drop_cnt            saturating count of flushed valid entries
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int WIDTH = 32,
    parameter int MODE  = 0,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] drop_cnt
);

    // Sum width wide enough to hold CNT_W-bit max + 2 without wrapping.
    localparam int SW = ((CNT_W > 2) ? CNT_W : 2) + 1;

    logic             r_out_v;
    logic [WIDTH-1:0] r_out_d;
    logic             r_s_v;
    logic [WIDTH-1:0] r_s_d;
    logic [CNT_W-1:0] r_cnt;

    logic             w_out_v_nxt;
    logic [WIDTH-1:0] w_out_d_nxt;
    logic             w_s_v_nxt;
    logic [WIDTH-1:0] w_s_d_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_rdy;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_occ;
    logic [SW-1:0]    w_sum;

    // Acceptance as seen by the datapath. The skid flop is the only MODE 1
    // term, which keeps out_ready off the in_ready path.
    assign w_rdy  = (MODE == 0) ? enable : (enable && !r_s_v);
    assign w_push = in_valid && w_rdy;
    assign w_pop  = r_out_v && out_ready && enable;
    assign w_occ  = {1'b0, r_out_v} + {1'b0, r_s_v};

    // During reset a MODE 1 stage is empty and advertises space at once.
    assign in_ready  = (MODE != 0 && !nRST) ? 1'b1 : w_rdy;
    assign out_valid = r_out_v;
    assign out_data  = r_out_d;
    assign occupancy = w_occ;
    assign drop_cnt  = r_cnt;

    assign w_sum = SW'(r_cnt) + SW'(w_occ);

    always_comb begin
        w_out_v_nxt = r_out_v;
        w_out_d_nxt = r_out_d;
        w_s_v_nxt   = r_s_v;
        w_s_d_nxt   = r_s_d;
        w_cnt_nxt   = r_cnt;

        if (flush) begin
            w_out_v_nxt = 1'b0;
            w_out_d_nxt = '0;
            w_s_v_nxt   = 1'b0;
            w_s_d_nxt   = '0;
            if (w_sum > SW'({CNT_W{1'b1}}))
                w_cnt_nxt = {CNT_W{1'b1}};
            else
                w_cnt_nxt = CNT_W'(w_sum);
        end else if (MODE == 0) begin
            if (enable) begin
                w_out_v_nxt = in_valid;
                w_out_d_nxt = in_data;
            end
        end else if (enable) begin
            if (!r_s_v) begin
                if (!r_out_v || w_pop) begin
                    // Main slot is free (or draining): refill straight from input.
                    w_out_v_nxt = w_push;
                    w_out_d_nxt = w_push ? in_data : '0;
                end else if (w_push) begin
                    // Downstream stalled: park the new entry in the skid slot.
                    w_s_v_nxt = 1'b1;
                    w_s_d_nxt = in_data;
                end
            end else if (w_pop) begin
                w_out_v_nxt = 1'b1;
                w_out_d_nxt = r_s_d;
                w_s_v_nxt   = 1'b0;
                w_s_d_nxt   = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_out_v <= 1'b0;
            r_out_d <= '0;
            r_s_v   <= 1'b0;
            r_s_d   <= '0;
            r_cnt   <= '0;
        end else begin
            r_out_v <= w_out_v_nxt;
            r_out_d <= w_out_d_nxt;
            r_s_v   <= w_s_v_nxt;
            r_s_d   <= w_s_d_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Directed bench for pipe_stage_reg. Three instances share one set of
//   inputs: MODE 0 (u_m0), MODE 1 (u_m1) and MODE 1 with a 2-bit drop
//   counter (u_sat). Expected values are written out by hand.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        flush, enable, in_valid, out_ready;
    logic [31:0] in_data;

    logic        m0_rdy, m0_v, m1_rdy, m1_v, st_rdy, st_v;
    logic [31:0] m0_d, m1_d, st_d;
    logic [1:0]  m0_occ, m1_occ, st_occ;
    logic [7:0]  m0_cnt, m1_cnt;
    logic [1:0]  st_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    pipe_stage_reg #(.WIDTH(32), .MODE(0), .CNT_W(8)) u_m0 (
        .CLK(CLK), .nRST(nRST), .flush(flush), .enable(enable),
        .in_valid(in_valid), .in_data(in_data), .in_ready(m0_rdy),
        .out_valid(m0_v), .out_data(m0_d), .out_ready(out_ready),
        .occupancy(m0_occ), .drop_cnt(m0_cnt));

    pipe_stage_reg #(.WIDTH(32), .MODE(1), .CNT_W(8)) u_m1 (
        .CLK(CLK), .nRST(nRST), .flush(flush), .enable(enable),
        .in_valid(in_valid), .in_data(in_data), .in_ready(m1_rdy),
        .out_valid(m1_v), .out_data(m1_d), .out_ready(out_ready),
        .occupancy(m1_occ), .drop_cnt(m1_cnt));

    pipe_stage_reg #(.WIDTH(32), .MODE(1), .CNT_W(2)) u_sat (
        .CLK(CLK), .nRST(nRST), .flush(flush), .enable(enable),
        .in_valid(in_valid), .in_data(in_data), .in_ready(st_rdy),
        .out_valid(st_v), .out_data(st_d), .out_ready(out_ready),
        .occupancy(st_occ), .drop_cnt(st_cnt));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock, then settle just past the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
    endtask

    // Fill the MODE 1 stages with 0x11 (main) and 0x22 (skid).
    task automatic fill2();
        enable = 1'b1; out_ready = 1'b0; flush = 1'b0;
        in_valid = 1'b1; in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        in_valid = 1'b0;
        check("fill_occ", {30'd0, m1_occ}, 32'd2);
    endtask

    initial begin
        nRST = 1'b0; flush = 1'b0; enable = 1'b1; in_valid = 1'b0;
        out_ready = 1'b0; in_data = '0;
        #12;
        check("rst_m0_v",   {31'd0, m0_v}, 32'd0);
        check("rst_m0_rdy", {31'd0, m0_rdy}, 32'd1);
        check("rst_m1_rdy", {31'd0, m1_rdy}, 32'd1);
        check("rst_m1_occ", {30'd0, m1_occ}, 32'd0);
        check("rst_m1_cnt", {24'd0, m1_cnt}, 32'd0);
        tick();
        nRST = 1'b1;

        // ---------------- MODE 0: load, stall, flush ----------------
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        tick();
        check("m0_load_v", {31'd0, m0_v}, 32'd1);
        check("m0_load_d", m0_d, 32'hDEADBEEF);
        check("m0_load_occ", {30'd0, m0_occ}, 32'd1);
        enable = 1'b0; in_data = 32'h12345678;
        #1;
        check("m0_rdy_stall", {31'd0, m0_rdy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("m0_stall_d", m0_d, 32'hDEADBEEF);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; enable = 1'b1;
        check("m0_flush_v", {31'd0, m0_v}, 32'd0);
        check("m0_flush_d", m0_d, 32'd0);
        check("m0_flush_cnt", {24'd0, m0_cnt}, 32'd1);

        // ---------------- MODE 1: back-pressure ----------------
        pulse_reset();
        tick();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        tick();
        check("bp_a_d", m1_d, 32'hA);
        check("bp_a_occ", {30'd0, m1_occ}, 32'd1);
        in_data = 32'hB;
        tick();
        check("bp_full_occ", {30'd0, m1_occ}, 32'd2);
        check("bp_full_rdy", {31'd0, m1_rdy}, 32'd0);
        in_data = 32'hC;
        tick();
        check("bp_hold_occ", {30'd0, m1_occ}, 32'd2);
        check("bp_out_a", m1_d, 32'hA);
        out_ready = 1'b1;
        tick();
        check("bp_out_b", m1_d, 32'hB);
        check("bp_b_occ", {30'd0, m1_occ}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_out_c", m1_d, 32'hC);
        check("bp_c_v", {31'd0, m1_v}, 32'd1);
        tick();
        check("bp_drain_v", {31'd0, m1_v}, 32'd0);
        check("bp_drain_occ", {30'd0, m1_occ}, 32'd0);

        // ---------------- MODE 1: streaming ----------------
        pulse_reset();
        tick();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = i;
            tick();
            check("st_v", {31'd0, m1_v}, 32'd1);
            check("st_d", m1_d, i);
            check("st_occ", {30'd0, m1_occ}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("st_end_v", {31'd0, m1_v}, 32'd0);

        // ---------------- MODE 1: flush when full + saturation ----------------
        pulse_reset();
        tick();
        fill2();
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h55;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl1_occ", {30'd0, m1_occ}, 32'd0);
        check("fl1_d", m1_d, 32'd0);
        check("fl1_cnt", {24'd0, m1_cnt}, 32'd2);
        check("fl1_sat", {30'd0, st_cnt}, 32'd2);
        check("fl1_rdy", {31'd0, m1_rdy}, 32'd1);
        tick();
        check("fl1_no55", {31'd0, m1_v}, 32'd0);

        fill2();
        enable = 1'b0; flush = 1'b1; in_valid = 1'b1; in_data = 32'h55;
        tick();
        flush = 1'b0; in_valid = 1'b0; enable = 1'b1;
        check("fl2_occ", {30'd0, m1_occ}, 32'd0);
        check("fl2_d", m1_d, 32'd0);
        check("fl2_cnt", {24'd0, m1_cnt}, 32'd4);
        check("fl2_sat", {30'd0, st_cnt}, 32'd3);

        fill2();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl3_cnt", {24'd0, m1_cnt}, 32'd6);
        check("fl3_sat", {30'd0, st_cnt}, 32'd3);
        tick();
        check("fl3_sat_hold", {30'd0, st_cnt}, 32'd3);

        // ---------------- async reset mid-stream ----------------
        fill2();
        #2;
        nRST = 1'b0;
        #1;
        check("arst_v", {31'd0, m1_v}, 32'd0);
        check("arst_d", m1_d, 32'd0);
        check("arst_occ", {30'd0, m1_occ}, 32'd0);
        check("arst_cnt", {24'd0, m1_cnt}, 32'd0);
        check("arst_rdy", {31'd0, m1_rdy}, 32'd1);
        #2;
        nRST = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register that generalises the fixed MEM/WB latch into a reusable block for any inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque packed payload of WIDTH bits plus a valid bit.
- Supports the existing enable/flush latch semantics (MODE 0).
- Adds an elastic ready/valid mode with a 2-entry skid buffer (MODE 1), for stages that must absorb back-pressure without a combinational ready path.
- Reports occupancy and a saturating count of valid entries discarded by flushes.

Parameters:
- WIDTH, 32, payload width in bits (≥1).
- MODE, 0, 0 = enable/flush latch; 1 = elastic 2-entry skid buffer.
- CNT_W, 8, width of the drop counter.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- flush  input  1  discard all held entries this cycle; highest priority.
- enable  input  1  stage advance / global stall gate; 0 = freeze.
- in_valid  input  1  upstream entry valid.
- in_data  input  WIDTH  upstream payload.
- in_ready  output  1  block can accept in_data this cycle.
- out_valid  output  1  downstream entry valid.
- out_data  output  WIDTH  downstream payload.
- out_ready  input  1  downstream accepts (MODE 1 only; ignored in MODE 0).
- occupancy  output  2  number of valid entries held (0..1 in MODE 0, 0..2 in MODE 1).
- drop_cnt  output  CNT_W  saturating count of valid entries discarded by flush.

Behaviour:
Reset (nRST=0, async):
- All state cleared: out_valid=0, out_data=0, occupancy=0, drop_cnt=0, skid entry invalid and zero.
- in_ready=1 in MODE 1; in_ready=enable in MODE 0.
- Reset asserted mid-operation discards all entries without incrementing drop_cnt.

Flush (both modes):
- On a rising edge with flush=1, all entries become invalid and all data registers become 0.
- drop_cnt += occupancy, saturating at 2^CNT_W−1.
- A concurrent in_valid input is dropped, not counted, and not captured.
- Flush overrides enable=0.

MODE 0 (latch):
- in_ready = enable (combinational).
- On each edge, if not flushing:
  - enable=1 → out_valid <= in_valid, out_data <= in_data.
  - enable=0 → hold both outputs.
- out_ready is ignored. Latency is 1 cycle. occupancy = out_valid.

MODE 1 (elastic):
- Holds a main entry (out_valid/out_data) and a skid entry (s_v/s_d).
- in_ready = enable && !s_v. s_v is a flop, so there is no combinational path from out_ready to in_ready.
- push = in_valid && in_ready. pop = out_valid && out_ready && enable.
- When s_v=0:
  - out_valid=0 or pop → main <= push ? in_data : invalid (out_data <= 0 if invalid).
  - out_valid=1 and no pop → push loads the skid entry (s_v <= 1).
- When s_v=1 (no push possible):
  - pop → main <= skid entry, s_v <= 0.
  - no pop → hold.
- enable=0 → no push, no pop, all state held.
- Order is strictly FIFO. Minimum latency is 1 cycle. Full throughput (1/cycle) holds while out_ready=1.
- occupancy = out_valid + s_v. s_v=1 implies out_valid=1.

drop_cnt holds at its maximum once saturated and is cleared only by reset.

Test Plan:
- Reset: drive nRST=0 mid-stream with 2 entries held in MODE 1 → out_valid=0, out_data=0, occupancy=0, drop_cnt=0, in_ready=1 immediately (asynchronous).
- MODE 0, stall and flush:
  - Load 0xDEADBEEF.
  - enable=0 for 3 cycles with in_data=0x12345678 → out_data stays 0xDEADBEEF.
  - flush=1 → out_valid=0, out_data=0, drop_cnt=1.
- MODE 1, back-pressure:
  - out_ready=0; push 0xA, 0xB → occupancy=2, in_ready=0.
  - Offer 0xC (not accepted); raise out_ready → outputs 0xA, 0xB, then 0xC, in order, with no loss or duplication.
- MODE 1, streaming: out_ready=1, push 0x1..0x8 back-to-back → out_data 0x1..0x8 on consecutive cycles after 1-cycle latency; occupancy never exceeds 1.
- MODE 1, flush when full:
  - occupancy=2, flush=1 with in_valid=1 and in_data=0x55 → occupancy=0, drop_cnt+=2, 0x55 not captured.
  - enable=0 together with flush → same result.
- Saturation: CNT_W=2; apply 3 flushes at occupancy=2 → drop_cnt=3 and stays 3.
